// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg
// Shared definitions for the OV7670 configuration path: the in-band ROM
// markers (also used by the ROM documentation and the bench) and the
// sequencer state encoding.
package ov7670_cfg_pkg;

  // End-of-table marker: the sequence finishes when this word is decoded.
  localparam logic [15:0] ROM_END   = 16'hFFFF;
  // Delay marker: pause the sequence for DELAY_CYCLES clocks.
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;
  // Highest ROM address; the walk never wraps past it.
  localparam logic [7:0]  ROM_LAST_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_DELAY,
    ST_DONE
  } cfg_state_e;

endpackage

// File: rtl/ov7670_delay_timer.sv
// ov7670_delay_timer
// Down-counter that times a ROM delay entry. A load pulse presets the
// counter to DELAY_CYCLES-1; it then decrements once per clock and holds
// at zero. 'expired' is high while the count is zero, so a load followed
// by waiting for 'expired' spans exactly DELAY_CYCLES cycles.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (counter -> 0)
//   load     in   preset the counter to DELAY_CYCLES-1
//   expired  out  counter has reached zero
module ov7670_delay_timer #(
  parameter int DELAY_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int W = $clog2(DELAY_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(DELAY_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer
// Walks the OV7670 configuration ROM from address 0, turning each 16-bit
// entry {reg, data} into one SCCB register-write request. Handles the
// in-band delay (ROM_DELAY) and end (ROM_END) markers, skips any other
// entry whose register byte is 8'hFF, and stops at address 255 if no end
// marker is found.
//
// Ports:
//   clk         in   system clock (rising edge)
//   rst_n       in   asynchronous active-low reset
//   start       in   level-sampled start/restart (honoured in IDLE/DONE)
//   rom_addr    out  ROM address, registered
//   rom_dout    in   ROM word, valid the cycle after rom_addr changes
//   sccb_valid  out  write request to the SCCB master
//   sccb_ready  in   SCCB master accepts when high together with valid
//   sccb_reg    out  register address of the request
//   sccb_data   out  register data of the request
//   busy        out  sequence in progress
//   done        out  sequence finished
//   wr_count    out  accepted writes since the last start, saturating
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int DELAY_CYCLES = 250000,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        sccb_valid,
  input  logic        sccb_ready,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  wr_count
);

  cfg_state_e state, state_nx;

  // High only in the first cycle after reset release; drives auto-start.
  logic first_cycle;

  logic begin_seq;
  logic latch_word;
  logic accepted;
  logic advance;
  logic timer_load;
  logic timer_expired;

  ov7670_delay_timer #(
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_delay_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      first_cycle <= 1'b1;
    end else begin
      state       <= state_nx;
      first_cycle <= 1'b0;
    end
  end

  always_comb begin
    state_nx   = state;
    begin_seq  = 1'b0;
    latch_word = 1'b0;
    accepted   = 1'b0;
    advance    = 1'b0;
    timer_load = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start || (AUTO_START && first_cycle)) begin
          begin_seq = 1'b1;
          state_nx  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (rom_dout == ROM_END) begin
          state_nx = ST_DONE;
        end else if (rom_dout == ROM_DELAY) begin
          timer_load = 1'b1;
          state_nx   = ST_DELAY;
        end else if (rom_dout[15:8] == 8'hFF) begin
          advance = 1'b1;
        end else begin
          latch_word = 1'b1;
          state_nx   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sccb_ready) begin
          accepted = 1'b1;
          advance  = 1'b1;
        end
      end
      ST_DELAY: begin
        if (timer_expired) begin
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          begin_seq = 1'b1;
          state_nx  = ST_FETCH;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Every way out of an entry funnels through here so the end-of-ROM
    // stop is handled in one place.
    if (advance) begin
      state_nx = (rom_addr == ROM_LAST_ADDR) ? ST_DONE : ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      sccb_reg  <= '0;
      sccb_data <= '0;
      wr_count  <= '0;
    end else begin
      if (begin_seq) begin
        rom_addr <= '0;
        wr_count <= '0;
      end else begin
        if (advance && (rom_addr != ROM_LAST_ADDR)) begin
          rom_addr <= rom_addr + 8'd1;
        end
        if (accepted && (wr_count != 8'hFF)) begin
          wr_count <= wr_count + 8'd1;
        end
      end
      if (latch_word) begin
        sccb_reg  <= rom_dout[15:8];
        sccb_data <= rom_dout[7:0];
      end
    end
  end

  assign sccb_valid = (state == ST_SEND);
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer
// Drives two sequencers from stub ROMs: one auto-starting with a short
// delay, one waiting for start. Transfers are collected by a monitor and
// compared against a table walk computed from the ROM contents.
module tb_ov7670_config_sequencer;
  import ov7670_cfg_pkg::*;

  localparam int DLY = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        sccb_valid;
  logic        sccb_ready;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        busy;
  logic        done;
  logic [7:0]  wr_count;

  logic        start_b;
  logic [7:0]  rom_addr_b;
  logic [15:0] rom_dout_b;
  logic        sccb_valid_b;
  logic        sccb_ready_b;
  logic [7:0]  sccb_reg_b;
  logic [7:0]  sccb_data_b;
  logic        busy_b;
  logic        done_b;
  logic [7:0]  wr_count_b;

  logic [15:0] rom [256];
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];

  int  n_tests;
  int  n_fail;
  int  cyc;
  int  stalls;
  int  acc0_cyc;
  int  addr2_cyc;
  bit  rand_ready;

  ov7670_config_sequencer #(.DELAY_CYCLES(DLY), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .sccb_valid(sccb_valid), .sccb_ready(sccb_ready),
    .sccb_reg(sccb_reg), .sccb_data(sccb_data), .busy(busy), .done(done),
    .wr_count(wr_count)
  );

  ov7670_config_sequencer #(.DELAY_CYCLES(DLY), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rom_addr(rom_addr_b),
    .rom_dout(rom_dout_b), .sccb_valid(sccb_valid_b), .sccb_ready(sccb_ready_b),
    .sccb_reg(sccb_reg_b), .sccb_data(sccb_data_b), .busy(busy_b), .done(done_b),
    .wr_count(wr_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM stubs, one per sequencer.
  always @(posedge clk) begin
    rom_dout   <= rom[rom_addr];
    rom_dout_b <= rom[rom_addr_b];
  end

  always @(posedge clk) cyc++;

  // Inputs change 1 ns after the rising edge, so the falling edge sees a
  // settled handshake that will take effect on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sccb_valid && sccb_ready) begin
        got_q.push_back({sccb_reg, sccb_data});
        if (rom_addr == 8'd0 && acc0_cyc < 0) acc0_cyc = cyc;
      end
      if (sccb_valid && !sccb_ready) stalls++;
      if (busy && rom_addr == 8'd2 && addr2_cyc < 0) addr2_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) sccb_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic clear_monitor();
    got_q.delete();
    stalls    = 0;
    acc0_cyc  = -1;
    addr2_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_monitor();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference: walk the table by its rules, collecting the expected
  // writes and the cycle count with an always-ready SCCB master.
  task automatic model_run(output int base, output int exp_addr);
    logic [15:0] w;
    exp_q.delete();
    base     = 0;
    exp_addr = 255;
    for (int a = 0; a < 256; a++) begin
      w = rom[a];
      if (w == ROM_END) begin
        base += 2;
        exp_addr = a;
        break;
      end else if (w == ROM_DELAY) begin
        base += 2 + DLY;
      end else if (w[15:8] == 8'hFF) begin
        base += 2;
      end else begin
        base += 3;
        exp_q.push_back(w);
      end
    end
  endtask

  function automatic bit q_equal();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Runs from the edge that starts the sequence until done; t is the
  // number of cycles between that edge and done becoming visible.
  task automatic run_until_done(input bit via_start, output int t);
    t = 0;
    if (via_start) begin
      clear_monitor();
      start = 1'b1;
      tick();
      start = 1'b0;
    end else begin
      tick();
    end
    while (!done && t < 20000) begin
      tick();
      t++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL run_timeout: done=%0b after %0d cycles, required 1", done, t);
    end
  endtask

  task automatic load_stub();
    foreach (rom[i]) rom[i] = ROM_END;
    rom[0] = 16'h1280;
    rom[1] = ROM_DELAY;
    rom[2] = 16'h1210;
    rom[3] = ROM_END;
  endtask

  task automatic test_reset();
    load_stub();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done, wr_count} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_a: outputs=%h required 0",
               {rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done, wr_count});
    end
    n_tests++;
    if ({rom_addr_b, sccb_valid_b, sccb_reg_b, sccb_data_b, busy_b, done_b, wr_count_b} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_b: outputs=%h required 0",
               {rom_addr_b, sccb_valid_b, sccb_reg_b, sccb_data_b, busy_b, done_b, wr_count_b});
    end
  endtask

  task automatic test_auto_start_off();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy_b || sccb_valid_b || done_b || rom_addr_b != 8'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL idle_no_start: active cycles=%0d required 0", bad);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_tests++;
    if (busy_b !== 1'b1 || sccb_valid_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_fetch: busy=%0b valid=%0b required 1/0", busy_b, sccb_valid_b);
    end
    tick();
    n_tests++;
    if (sccb_valid_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_decode: valid=%0b required 0", sccb_valid_b);
    end
    tick();
    n_tests++;
    if (sccb_valid_b !== 1'b1 || {sccb_reg_b, sccb_data_b} !== 16'h1280) begin
      n_fail++;
      $display("[TB] FAIL start_send: valid=%0b req=%h required 1/1280",
               sccb_valid_b, {sccb_reg_b, sccb_data_b});
    end
  endtask

  task automatic test_stub_rom();
    int t, base, ea;
    load_stub();
    model_run(base, ea);
    do_reset();
    run_until_done(1'b0, t);
    n_tests++;
    if (!q_equal() || got_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL stub_writes: got %0d writes first=%h, required 2 (1280,1210)",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 16'h0);
    end
    n_tests++;
    if (addr2_cyc - acc0_cyc - 1 != 10) begin
      n_fail++;
      $display("[TB] FAIL stub_delay_gap: %0d cycles, required 10", addr2_cyc - acc0_cyc - 1);
    end
    n_tests++;
    if (t != base) begin
      n_fail++;
      $display("[TB] FAIL stub_latency: %0d cycles, required %0d", t, base);
    end
    n_tests++;
    if (done !== 1'b1 || wr_count !== 8'd2 || rom_addr !== 8'(ea)) begin
      n_fail++;
      $display("[TB] FAIL stub_final: done=%0b wr_count=%0d addr=%0d required 1/2/%0d",
               done, wr_count, rom_addr, ea);
    end
  endtask

  task automatic test_backpressure();
    int waited;
    foreach (rom[i]) rom[i] = ROM_END;
    rom[0] = 16'h3A5C;
    sccb_ready = 1'b0;
    do_reset();
    waited = 0;
    while (!sccb_valid && waited < 10) begin
      tick();
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (sccb_valid !== 1'b1 || {sccb_reg, sccb_data} !== 16'h3A5C ||
          rom_addr !== 8'd0 || got_q.size() != 0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold%0d: valid=%0b req=%h addr=%0d xfers=%0d required 1/3a5c/0/0",
                 i, sccb_valid, {sccb_reg, sccb_data}, rom_addr, got_q.size());
      end
      tick();
    end
    sccb_ready = 1'b1;
    tick();
    n_tests++;
    if (got_q.size() != 1 || wr_count !== 8'd1 || rom_addr !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL bp_release: xfers=%0d wr_count=%0d addr=%0d required 1/1/1",
               got_q.size(), wr_count, rom_addr);
    end
    n_tests++;
    if (stalls != 5) begin
      n_fail++;
      $display("[TB] FAIL bp_stalls: %0d stalled cycles, required 5", stalls);
    end
  endtask

  task automatic test_no_end();
    int t, base, ea;
    foreach (rom[i]) rom[i] = 16'h0C04;
    model_run(base, ea);
    do_reset();
    run_until_done(1'b0, t);
    n_tests++;
    if (got_q.size() != 256 || !q_equal()) begin
      n_fail++;
      $display("[TB] FAIL noend_writes: got %0d, required 256", got_q.size());
    end
    n_tests++;
    if (wr_count !== 8'd255 || rom_addr !== 8'd255 || done !== 1'b1 || t != base) begin
      n_fail++;
      $display("[TB] FAIL noend_final: wr_count=%0d addr=%0d done=%0b cycles=%0d required 255/255/1/%0d",
               wr_count, rom_addr, done, t, base);
    end
  endtask

  task automatic test_skip_start();
    int t, base, ea;
    bit pulsed;
    foreach (rom[i]) rom[i] = ROM_END;
    rom[0] = 16'h1111;
    rom[1] = 16'hFF12;
    rom[2] = 16'h2233;
    model_run(base, ea);
    do_reset();
    tick();
    t = 0;
    pulsed = 1'b0;
    while (!done && t < 200) begin
      if (sccb_valid && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      start = 1'b0;
      t++;
    end
    n_tests++;
    if (!q_equal() || t != base || wr_count !== 8'd2 || rom_addr !== 8'd3) begin
      n_fail++;
      $display("[TB] FAIL skip_run: writes=%0d cycles=%0d wr_count=%0d addr=%0d required 2/%0d/2/3",
               got_q.size(), t, wr_count, rom_addr, base);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (rom_addr !== 8'd0 || wr_count !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_restart: addr=%0d wr_count=%0d busy=%0b done=%0b required 0/0/1/0",
               rom_addr, wr_count, busy, done);
    end
  endtask

  task automatic test_reset_midway();
    int t, base, ea, waited;
    load_stub();
    model_run(base, ea);
    for (int pass = 0; pass < 2; pass++) begin
      sccb_ready = (pass == 0);
      do_reset();
      waited = 0;
      if (pass == 0) begin
        while (!(busy && rom_addr == 8'd1) && waited < 50) begin
          tick();
          waited++;
        end
        tick();
        tick();
        tick();
      end else begin
        while (!sccb_valid && waited < 50) begin
          tick();
          waited++;
        end
        tick();
      end
      n_tests++;
      if (busy !== 1'b1 || sccb_valid !== (pass == 1)) begin
        n_fail++;
        $display("[TB] FAIL mid_prep%0d: busy=%0b valid=%0b required 1/%0b",
                 pass, busy, sccb_valid, pass == 1);
      end
      rst_n = 1'b0;
      clear_monitor();
      #1;
      n_tests++;
      if ({rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done, wr_count} !== 35'd0) begin
        n_fail++;
        $display("[TB] FAIL mid_reset%0d: outputs=%h required 0", pass,
                 {rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done, wr_count});
      end
      sccb_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      run_until_done(1'b0, t);
      n_tests++;
      if (!q_equal() || t != base || wr_count !== 8'd2) begin
        n_fail++;
        $display("[TB] FAIL mid_rerun%0d: writes=%0d cycles=%0d wr_count=%0d required 2/%0d/2",
                 pass, got_q.size(), t, wr_count, base);
      end
    end
  endtask

  task automatic test_random();
    int t, base, ea, r;
    logic [7:0] hi, lo;
    for (int it = 0; it < 6; it++) begin
      foreach (rom[i]) begin
        r  = $urandom_range(0, 99);
        lo = 8'($urandom);
        hi = 8'($urandom_range(0, 254));
        if (r < 62) rom[i] = {hi, lo};
        else if (r < 74) rom[i] = {8'hFF, 8'($urandom_range(0, 239))};
        else if (r < 80) rom[i] = ROM_DELAY;
        else if (r < 84 && it != 0) rom[i] = ROM_END;
        else rom[i] = {hi, lo};
      end
      model_run(base, ea);
      rand_ready = 1'b1;
      if (it == 0) begin
        do_reset();
        run_until_done(1'b0, t);
      end else begin
        run_until_done(1'b1, t);
      end
      rand_ready = 1'b0;
      sccb_ready = 1'b1;
      n_tests++;
      if (!q_equal()) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_writes: got %0d writes, required %0d in table order",
                 it, got_q.size(), exp_q.size());
      end
      n_tests++;
      if (t != base + stalls || rom_addr !== 8'(ea) ||
          wr_count !== ((exp_q.size() > 255) ? 8'd255 : 8'(exp_q.size()))) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_final: cycles=%0d addr=%0d wr_count=%0d required %0d/%0d/%0d",
                 it, t, rom_addr, wr_count, base + stalls, ea,
                 (exp_q.size() > 255) ? 255 : exp_q.size());
      end
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    cyc          = 0;
    rand_ready   = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    start_b      = 1'b0;
    sccb_ready   = 1'b1;
    sccb_ready_b = 1'b1;
    clear_monitor();

    test_reset();
    test_auto_start_off();
    test_stub_rom();
    test_backpressure();
    test_no_end();
    test_skip_start();
    test_reset_midway();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Walks the OV7670 register-configuration ROM from address 0 and turns each 16-bit entry into one SCCB register-write request, honouring the ROM's in-band delay (16'hFFF0) and end (16'hFFFF) markers. Sits between the configuration ROM (1-cycle registered read) and the SCCB master, and reports `busy`/`done` to top-level camera bring-up logic. It is the read side of the ROM interface.

## Interface
- `DELAY_CYCLES`, default 250000: length of a delay entry in `clk` cycles (10 ms at 25 MHz); legal range ≥1.
- `AUTO_START`, default 1: 1 = begin the sequence on the first cycle after reset release; 0 = wait for `start`.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; starts or restarts the sequence when in IDLE or DONE.
- `rom_addr`  out  8  ROM address (registered).
- `rom_dout`  in  16  ROM word; valid one cycle after `rom_addr` changes; `{reg[15:8], data[7:0]}`.
- `sccb_valid`  out  1  write request to the SCCB master.
- `sccb_ready`  in  1  SCCB master can accept; transfer on `sccb_valid & sccb_ready`.
- `sccb_reg`  out  8  register address for the request.
- `sccb_data`  out  8  register data for the request.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE only.
- `wr_count`  out  8  SCCB writes accepted since the last start; saturates at 255.

## Operation
- States: IDLE, FETCH, DECODE, SEND, DELAY, DONE.
- IDLE: enter FETCH with `rom_addr`=0 and `wr_count`=0 when `start`=1, or unconditionally on the first cycle after reset if `AUTO_START`=1.
- FETCH: one cycle. Hold `rom_addr` and go to DECODE.
- DECODE: sample `rom_dout`.
  - 16'hFFFF → DONE.
  - 16'hFFF0 → DELAY, loading the counter with DELAY_CYCLES-1.
  - Any other word with [15:8]=8'hFF → skip: no write; advance.
  - Otherwise → latch `sccb_reg`/`sccb_data` and go to SEND.
- SEND: hold `sccb_valid`=1 with `sccb_reg`/`sccb_data` stable until the transfer cycle. At that edge, `wr_count`+1 (saturating), then advance.
- DELAY: count down to 0 (DELAY_CYCLES cycles in total), then advance.
- Advance:
  - If `rom_addr`=255 → DONE. No wrap to 0.
  - Else `rom_addr`+1 → FETCH.
- DONE: `done`=1. `start`=1 restarts exactly as from IDLE.
- `start` in FETCH/DECODE/SEND/DELAY is ignored.
- `sccb_valid` is never withdrawn before the transfer cycle.

## Timing
- Reset values: state IDLE; `rom_addr`=0, `sccb_valid`=0, `sccb_reg`=0, `sccb_data`=0, `busy`=0, `done`=0, `wr_count`=0. The delay counter resets to 0.
- Reset mid-operation (including during SEND) drops all outputs to their reset values immediately. The SCCB master must tolerate `sccb_valid` vanishing.
- After `start` is sampled high at edge E0 in IDLE:
  - FETCH is active in the cycle after E0, with `busy`=1.
  - DECODE follows after E1.
  - `sccb_valid` rises after E2, i.e. 3 cycles after `start` is sampled.
- With `sccb_ready` held high, each plain entry takes 3 cycles (FETCH, DECODE, SEND). Each `sccb_ready`-low cycle adds one cycle.
- A delay entry occupies FETCH + DECODE + DELAY_CYCLES cycles.
- `done` rises in the cycle after the DECODE of 16'hFFFF, or after the last advance from address 255.

## Structure
- Shared package `ov7670_cfg_pkg` holds:
  - `ROM_END`=16'hFFFF and `ROM_DELAY`=16'hFFF0, also used by the ROM's documentation and by the bench.
  - The state enum.
- One natural sub-module: `ov7670_delay_timer` (load, count-down, `expired` flag), width $clog2(DELAY_CYCLES+1).
- No other hierarchy. Expected size is about 150–250 lines.

## Test plan
- Stub ROM {0:16'h1280, 1:16'hFFF0, 2:16'h1210, 3:16'hFFFF}, DELAY_CYCLES=8, `sccb_ready`=1:
  - Exactly two transfers: (12,80) then (12,10).
  - 10 cycles between the accept at addr 0 and FETCH at addr 2.
  - `done`=1 and `wr_count`=2.
- Backpressure: hold `sccb_ready`=0 for 5 cycles during entry 0.
  - `sccb_valid`, `sccb_reg`, `sccb_data` stay stable.
  - The single transfer happens on the first ready cycle; `rom_addr` does not advance before it.
- ROM with no FFFF marker (every address returns 16'h0C04): 256 writes are issued, `wr_count`=255 (saturated), `done`=1, and `rom_addr` stops at 255.
- Skip and ignored start:
  - Entry 16'hFF12 produces no write.
  - `start` pulsed during SEND has no effect.
  - `start` in DONE restarts at addr 0 with `wr_count` cleared.
- Async reset during DELAY and during SEND: outputs go to their reset values within the same cycle. With AUTO_START=1, the sequence reruns from addr 0 after release.
- AUTO_START=0: no activity for 20 cycles after reset. `start`=1 gives `sccb_valid` 3 cycles later.
